// File: rtl/cordic_rot.sv
// Iterative rotation-mode CORDIC: (magnitude, angle in millidegrees) -> (x, y).
// One micro-rotation per clock, valid/ready handshakes on both sides.
module cordic_rot #(
    parameter int DATA_W = 16,
    parameter int ANG_W  = 18,
    parameter int ITERS  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] mag_in,
    input  logic signed [ANG_W-1:0]  ang_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] x_out,
    output logic signed [DATA_W-1:0] y_out
);

    localparam int XW = DATA_W + 2;
    localparam int PW = DATA_W + 17;
    localparam int CW = $clog2(ITERS) + 1;

    localparam logic signed [ANG_W:0]  QUARTER = (ANG_W + 1)'(90000);
    localparam logic signed [ANG_W:0]  HALF    = (ANG_W + 1)'(180000);
    localparam logic signed [PW-1:0]   GAIN    = PW'(19898);
    localparam logic signed [XW-1:0]   SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [XW-1:0]   SAT_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic signed [XW-1:0]    x, y;
    logic signed [ANG_W-1:0] z;
    logic [CW-1:0]           iter;

    logic signed [ANG_W:0]   ang_ext, z_fold;
    logic signed [DATA_W:0]  m;
    logic signed [PW-1:0]    prod, prod_sh;
    logic signed [XW-1:0]    x_load;
    logic signed [ANG_W-1:0] z_load;
    logic signed [XW-1:0]    x_sh, y_sh, x_nxt, y_nxt;
    logic signed [ANG_W-1:0] z_nxt, atan_val;

    function automatic logic signed [ANG_W-1:0] atan_lut(input logic [CW-1:0] idx);
        case (idx)
            0:       atan_lut = ANG_W'(45000);
            1:       atan_lut = ANG_W'(26565);
            2:       atan_lut = ANG_W'(14036);
            3:       atan_lut = ANG_W'(7125);
            4:       atan_lut = ANG_W'(3576);
            5:       atan_lut = ANG_W'(1790);
            6:       atan_lut = ANG_W'(895);
            7:       atan_lut = ANG_W'(448);
            8:       atan_lut = ANG_W'(224);
            9:       atan_lut = ANG_W'(112);
            10:      atan_lut = ANG_W'(56);
            11:      atan_lut = ANG_W'(28);
            12:      atan_lut = ANG_W'(14);
            13:      atan_lut = ANG_W'(7);
            14:      atan_lut = ANG_W'(3);
            15:      atan_lut = ANG_W'(2);
            default: atan_lut = '0;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
        else if (v < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
        else                  sat = v[DATA_W-1:0];
    endfunction

    // Fold the angle into [-90, +90] deg by negating the magnitude, then pre-scale by 1/K.
    always_comb begin
        ang_ext = {ang_in[ANG_W-1], ang_in};
        z_fold  = ang_ext;
        m       = {mag_in[DATA_W-1], mag_in};
        if (ang_ext > QUARTER) begin
            z_fold = ang_ext - HALF;
            m      = -{mag_in[DATA_W-1], mag_in};
        end else if (ang_ext < -QUARTER) begin
            z_fold = ang_ext + HALF;
            m      = -{mag_in[DATA_W-1], mag_in};
        end
        z_load  = z_fold[ANG_W-1:0];
        prod    = {{(PW-DATA_W-1){m[DATA_W]}}, m} * GAIN;
        prod_sh = prod >>> 15;
        x_load  = prod_sh[XW-1:0];
    end

    always_comb begin
        atan_val = atan_lut(iter);
        x_sh     = x >>> iter;
        y_sh     = y >>> iter;
        if (!z[ANG_W-1]) begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - atan_val;
        end else begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + atan_val;
        end
    end

    // The final micro-rotation is saturated straight into the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            iter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        x        <= x_load;
                        y        <= '0;
                        z        <= z_load;
                        iter     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    x <= x_nxt;
                    y <= y_nxt;
                    z <= z_nxt;
                    if (iter == CW'(ITERS - 1)) begin
                        x_out     <= sat(x_nxt);
                        y_out     <= sat(y_nxt);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rot.sv
// Directed bench for cordic_rot: reset state, latency, fold, saturation edge,
// held output handshake and mid-run reset abort.
module tb_cordic_rot;

    localparam int DATA_W = 16;
    localparam int ANG_W  = 18;
    localparam int ITERS  = 16;
    localparam int TOL    = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] mag_in;
    logic signed [ANG_W-1:0]  ang_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] x_out;
    logic signed [DATA_W-1:0] y_out;

    int checks   = 0;
    int failures = 0;
    int accepts  = 0;

    cordic_rot #(.DATA_W(DATA_W), .ANG_W(ANG_W), .ITERS(ITERS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mag_in(mag_in), .ang_in(ang_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (in_valid && in_ready) accepts++;
    end

    task automatic check_output(input string tag, input int actual, input int expected, input int tol);
        checks++;
        if (actual < expected - tol || actual > expected + tol) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (+/-%0d)", tag, actual, expected, tol);
        end
    endtask

    // Present one operand pair, check the accept and the ITERS-edge latency, then the result.
    task automatic apply_stimulus(input int mag, input int ang, input bit hold,
                                  input int ex, input int ey, input string tag);
        int lat;
        @(negedge clk);
        check_output({tag, "_rdy"}, int'(in_ready), 1, 0);
        mag_in   = DATA_W'(mag);
        ang_in   = ANG_W'(ang);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = hold;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_output({tag, "_lat"}, lat, ITERS, 0);
        check_output({tag, "_x"}, int'(x_out), ex, TOL);
        check_output({tag, "_y"}, int'(y_out), ey, TOL);
    endtask

    task automatic finish_op(input int stall, input int ex, input int ey, input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_output({tag, "_hold_v"}, int'(out_valid), 1, 0);
            check_output({tag, "_hold_x"}, int'(x_out), ex, TOL);
            check_output({tag, "_hold_y"}, int'(y_out), ey, TOL);
            check_output({tag, "_hold_rdy"}, int'(in_ready), 0, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_output({tag, "_rel_v"}, int'(out_valid), 0, 0);
        check_output({tag, "_rel_rdy"}, int'(in_ready), 1, 0);
        check_output({tag, "_keep_x"}, int'(x_out), ex, TOL);
    endtask

    initial begin
        int acc0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mag_in    = '0;
        ang_in    = '0;
        repeat (2) @(negedge clk);
        check_output("rst_rdy", int'(in_ready), 1, 0);
        check_output("rst_ov", int'(out_valid), 0, 0);
        check_output("rst_x", int'(x_out), 0, 0);
        check_output("rst_y", int'(y_out), 0, 0);
        rst = 1'b0;

        apply_stimulus(10000, 0, 1'b0, 10000, 0, "a0");
        finish_op(0, 10000, 0, "a0");

        apply_stimulus(10000, 30000, 1'b0, 8660, 5000, "a30");
        finish_op(5, 8660, 5000, "a30");

        apply_stimulus(10000, 120000, 1'b0, -5000, 8660, "a120");
        finish_op(0, -5000, 8660, "a120");

        apply_stimulus(10000, -90000, 1'b0, 0, -10000, "am90");
        finish_op(0, 0, -10000, "am90");

        acc0 = accepts;
        apply_stimulus(32767, 45000, 1'b1, 23170, 23170, "a45");
        check_output("a45_rdy_run", int'(in_ready), 0, 0);
        finish_op(1, 23170, 23170, "a45");
        check_output("a45_accepts", accepts - acc0, 1, 0);

        // Abort an operation partway through its iterations.
        @(negedge clk);
        mag_in   = DATA_W'(20000);
        ang_in   = ANG_W'(10000);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort_ov", int'(out_valid), 0, 0);
        check_output("abort_rdy", int'(in_ready), 1, 0);
        #1;
        rst = 1'b0;

        apply_stimulus(5000, 60000, 1'b0, 2500, 4330, "a60");
        finish_op(0, 2500, 4330, "a60");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
